// File: rtl/video_pattern_gen_if.sv
// Parallel video bus feeding the HDMI transmitter: data enable, syncs and
// 36-bit RGB pixel data ([35:24] R, [23:12] G, [11:0] B).
interface video_pattern_gen_if;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [35:0] d;

  modport master (output de, output hsync, output vsync, output d);
  modport slave  (input de, input hsync, input vsync, input d);
endinterface

// File: rtl/video_pattern_gen.sv
// Free-running video timing and test-pattern generator. Counters walk the
// raster (active, front porch, sync, back porch) and every output is
// registered once from counter state, so de, syncs, data and frame_start
// stay mutually aligned.
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 pattern_sel,
  video_pattern_gen_if.master        vid,
  output logic                       frame_start,
  output logic [7:0]                 frame_cnt
);

  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [1:0]    pat_q, pat_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic          de_c, hs_c, vs_c;
  logic [10:0]   sum_c;
  logic [35:0]   pix_c;

  logic          de_q, hs_q, vs_q, fs_q;
  logic [35:0]   d_q;

  // Raster counters plus the bar sub-counter that replaces a divide by H_ACTIVE/8.
  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    bar_px_d    = bar_px_q;
    bar_idx_d   = bar_idx_q;
    pat_d       = pat_q;
    frame_cnt_d = frame_cnt_q;
    if (!enable) begin
      // Idle parks at the frame origin, so the pattern is sampled there too.
      h_d       = '0;
      v_d       = '0;
      bar_px_d  = '0;
      bar_idx_d = '0;
      pat_d     = pattern_sel;
    end else if (h_q == H_LAST) begin
      h_d       = '0;
      bar_px_d  = '0;
      bar_idx_d = '0;
      if (v_q == V_LAST) begin
        v_d         = '0;
        pat_d       = pattern_sel;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        v_d = v_q + 1'b1;
      end
    end else begin
      h_d = h_q + 1'b1;
      if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end
  end

  // Counter state register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      bar_px_q    <= '0;
      bar_idx_q   <= '0;
      pat_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      bar_px_q    <= bar_px_d;
      bar_idx_q   <= bar_idx_d;
      pat_q       <= pat_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Decode timing and pixel value from the current counter state.
  always_comb begin
    de_c  = (h_q < H_ACT) && (v_q < V_ACT);
    hs_c  = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? HS_POL : ~HS_POL;
    vs_c  = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? VS_POL : ~VS_POL;
    sum_c = h_q[10:0] + {3'b000, frame_cnt_q};
    pix_c = '0;
    unique case (pat_q)
      2'd0: pix_c = {36{1'b1}};
      // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
      2'd1: pix_c = {{12{~bar_idx_q[1]}}, {12{~bar_idx_q[2]}}, {12{~bar_idx_q[0]}}};
      2'd2: pix_c = {3{h_q[9:0], 2'b00}};
      2'd3: pix_c = {36{sum_c[4] ^ v_q[4]}};
    endcase
  end

  // Output register: one cycle behind the counters, idle when reset or disabled.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      d_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      de_q <= de_c;
      hs_q <= hs_c;
      vs_q <= vs_c;
      d_q  <= de_c ? pix_c : 36'd0;
      fs_q <= (h_q == '0) && (v_q == '0);
    end
  end

  assign vid.de      = de_q;
  assign vid.hsync   = hs_q;
  assign vid.vsync   = vs_q;
  assign vid.d       = d_q;
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen. The main instance keeps full 800-pixel lines
// but a short frame; a tiny second instance exercises frame_cnt wrapping.
module tb_video_pattern_gen;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 17, VF = 1, VS = 2, VB = 1;
  localparam int H_T = HA + HF + HS + HB;
  localparam int V_T = VA + VF + VS + VB;
  localparam bit HS_POL_TB = 1'b0;
  localparam bit VS_POL_TB = 1'b0;

  logic       clk;
  logic       reset, enable;
  logic [1:0] pattern_sel;
  logic       frame_start;
  logic [7:0] frame_cnt;

  logic       s_reset, s_enable;
  logic [1:0] s_sel;
  logic       s_fs;
  logic [7:0] s_fcnt;

  video_pattern_gen_if vid ();
  video_pattern_gen_if s_vid ();

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HS_POL_TB), .VS_POL(VS_POL_TB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .vid(vid), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  video_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_small (
    .clk(clk), .reset(s_reset), .enable(s_enable), .pattern_sel(s_sel),
    .vid(s_vid), .frame_start(s_fs), .frame_cnt(s_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Vector layout: de[47] hsync[46] vsync[45] frame_start[44] frame_cnt[43:36] d[35:0]
  typedef struct {
    logic [47:0] exp;
    int          spot;
    logic [47:0] mask;
    logic [47:0] sexp;
  } sb_item_t;

  sb_item_t sb[$];

  localparam logic [47:0] D_MASK = 48'h000F_FFFF_FFFF;

  function automatic string spot_name(input int id);
    case (id)
      1: return "bar79";
      2: return "bar80";
      3: return "bar240";
      4: return "bar639";
      5: return "ramp639";
      6: return "white_hold";
      7: return "reenable_fs";
      8: return "reset_idle";
      default: return "spot";
    endcase
  endfunction

  function automatic logic [35:0] model_pix(input int h, input int v, input int pat,
                                            input int fcnt);
    logic [11:0] c;
    int bar;
    case (pat)
      0: return 36'hFFF_FFF_FFF;
      1: begin
        bar = h / (HA / 8);
        case (bar)
          0: return 36'hFFF_FFF_FFF;
          1: return 36'hFFF_FFF_000;
          2: return 36'h000_FFF_FFF;
          3: return 36'h000_FFF_000;
          4: return 36'hFFF_000_FFF;
          5: return 36'hFFF_000_000;
          6: return 36'h000_000_FFF;
          default: return 36'h0;
        endcase
      end
      2: begin
        c = 12'((h % 1024) * 4);
        return {c, c, c};
      end
      default: begin
        if (((((h + fcnt) % 2048) / 16) % 2) != ((v / 16) % 2)) return 36'hFFF_FFF_FFF;
        return 36'h0;
      end
    endcase
  endfunction

  // Reference model state.
  int m_h = 0, m_v = 0, m_pat = 0, m_fcnt = 0;
  bit prev_en = 1'b0, prev_rst = 1'b0;
  bit steady = 1'b0;

  // Push the expectation for the coming edge, then wait for the next negedge.
  task automatic tick();
    sb_item_t n;
    bit       de;
    n.exp  = '0;
    n.spot = 0;
    n.mask = '0;
    n.sexp = '0;
    if (reset) begin
      n.exp = {1'b0, ~HS_POL_TB, ~VS_POL_TB, 1'b0, 8'h00, 36'h0};
      m_h = 0; m_v = 0; m_pat = 0; m_fcnt = 0;
      if (!prev_rst) begin
        n.spot = 8; n.mask = {48{1'b1}}; n.sexp = 48'h6000_0000_0000;
      end
    end else if (!enable) begin
      n.exp = {1'b0, ~HS_POL_TB, ~VS_POL_TB, 1'b0, 8'(m_fcnt), 36'h0};
      m_h = 0; m_v = 0; m_pat = int'(pattern_sel);
    end else begin
      de = (m_h < HA) && (m_v < VA);
      n.exp[47] = de;
      n.exp[46] = (m_h >= HA + HF && m_h < HA + HF + HS) ? HS_POL_TB : ~HS_POL_TB;
      n.exp[45] = (m_v >= VA + VF && m_v < VA + VF + VS) ? VS_POL_TB : ~VS_POL_TB;
      n.exp[44] = (m_h == 0) && (m_v == 0);
      n.exp[35:0] = de ? model_pix(m_h, m_v, m_pat, m_fcnt) : 36'h0;
      if (m_pat == 1 && m_v == 0) begin
        case (m_h)
          79:  begin n.spot = 1; n.sexp = {12'h0, 36'hFFF_FFF_FFF}; end
          80:  begin n.spot = 2; n.sexp = {12'h0, 36'hFFF_FFF_000}; end
          240: begin n.spot = 3; n.sexp = {12'h0, 36'h000_FFF_000}; end
          639: begin n.spot = 4; n.sexp = {12'h0, 36'h000_000_000}; end
          default: ;
        endcase
      end
      if (m_pat == 2 && m_v == 0 && m_h == 639) begin
        n.spot = 5; n.sexp = {12'h0, 36'h9FC_9FC_9FC};
      end
      if (m_pat == 0 && m_v == 5 && m_h == 639) begin
        n.spot = 6; n.sexp = {12'h0, 36'hFFF_FFF_FFF};
      end
      if (n.spot != 0) n.mask = D_MASK;
      if (!prev_en) begin
        n.spot = 7; n.mask = 48'h9000_0000_0000; n.sexp = 48'h9000_0000_0000;
      end
      m_h++;
      if (m_h == H_T) begin
        m_h = 0;
        m_v++;
        if (m_v == V_T) begin
          m_v = 0;
          m_fcnt = (m_fcnt + 1) % 256;
          m_pat = int'(pattern_sel);
        end
      end
      n.exp[43:36] = 8'(m_fcnt);
    end
    sb.push_back(n);
    prev_en  = enable;
    prev_rst = reset;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Output monitor: scoreboard pop plus run-length timing measurements.
  sb_item_t    it;
  logic [47:0] obs;
  int de_len = 0, hs_len = 0, vs_len = 0, hgap = 0, vgap = 0, fgap = 0;
  bit de_prev = 1'b0, hs_prev = 1'b0, vs_prev = 1'b0, de_fell = 1'b0, fs_seen = 1'b0;
  bit hs_act, vs_act;

  always @(posedge clk) begin
    #1;
    obs = {vid.de, vid.hsync, vid.vsync, frame_start, frame_cnt, vid.d};
    if (sb.size() != 0) begin
      it = sb.pop_front();
      check("outputs", obs, it.exp);
      if (it.spot != 0) check(spot_name(it.spot), obs & it.mask, it.sexp & it.mask);
    end
    hs_act = (vid.hsync === HS_POL_TB);
    vs_act = (vid.vsync === VS_POL_TB);
    if (steady) begin
      if (vid.de === 1'b1) begin
        de_len++;
      end else if (de_prev) begin
        check("de_len", 48'(de_len), 48'(HA));
        de_len = 0; de_fell = 1'b1; hgap = 0; vgap = 0;
      end else begin
        hgap++; vgap++;
      end
      if (hs_act) hs_len++;
      if (hs_act && !hs_prev && de_fell) begin
        check("hs_delay", 48'(hgap), 48'(HF));
        de_fell = 1'b0;
      end
      if (!hs_act && hs_prev) begin
        check("hs_len", 48'(hs_len), 48'(HS));
        hs_len = 0;
      end
      if (vs_act) vs_len++;
      if (vs_act && !vs_prev) check("vs_delay", 48'(vgap), 48'((H_T - HA) + VF * H_T));
      if (!vs_act && vs_prev) begin
        check("vs_len", 48'(vs_len), 48'(VS * H_T));
        vs_len = 0;
      end
      fgap++;
      if (frame_start === 1'b1) begin
        if (fs_seen) check("fs_period", 48'(fgap), 48'(H_T * V_T));
        fgap = 0; fs_seen = 1'b1;
      end
    end
    de_prev = (vid.de === 1'b1);
    hs_prev = hs_act;
    vs_prev = vs_act;
  end

  // Small instance: frame_cnt must equal the number of completed frames mod 256.
  int s_n = 0, s_gap = 0;
  always @(posedge clk) begin
    #1;
    s_gap++;
    if (s_fs === 1'b1) begin
      check("s_fcnt", {40'h0, s_fcnt}, 48'(s_n % 256));
      if (s_n > 0) check("s_period", 48'(s_gap), 48'd44);
      s_n++;
      s_gap = 0;
    end
  end

  initial begin
    s_reset = 1'b1; s_enable = 1'b1; s_sel = 2'd0;
    repeat (3) @(negedge clk);
    s_reset = 1'b0;
  end

  initial begin
    reset = 1'b1; enable = 1'b1; pattern_sel = 2'd0;
    run(5);
    reset = 1'b0; steady = 1'b1;
    run(4 * H_T);  pattern_sel = 2'd2;   // frame 1 stays white
    run(17 * H_T);
    run(4 * H_T);  pattern_sel = 2'd1;   // frame 2 ramp
    run(17 * H_T);
    run(4 * H_T);  pattern_sel = 2'd3;   // frame 3 bars
    run(17 * H_T);
    run(17 * H_T + 300);                 // frame 4 checker, stop mid-line
    steady = 1'b0; enable = 1'b0;
    run(50);
    enable = 1'b1;
    run(2000);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(100);
    @(posedge clk);
    #2;
    check("s_frames", 48'(s_n > 256), 48'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Free-running video timing and test-pattern generator that drives the SiI9136 HDMI transmitter's parallel input bus (de, hsync, vsync, 36-bit pixel data) in place of the current tied-off constants. It runs on the 25 MHz board oscillator, producing 640x480@60-class timing by default. It is the first stage of bringing up the transmitter path, before the SiI9233 receive path is looped through.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 0, vsync active level

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pixel clock (osc25_pad_in at top level)
- reset  in  1  synchronous, active-high
- enable  in  1  run timing; low = idle
- pattern_sel  in  2  0 solid white, 1 colour bars, 2 grey ramp, 3 scrolling checkerboard
- vid_de  out  1  data enable
- vid_hsync  out  1  horizontal sync
- vid_vsync  out  1  vertical sync
- vid_d  out  36  pixel: [35:24] R, [23:12] G, [11:0] B
- frame_start  out  1  one-cycle pulse with first active pixel of each frame
- frame_cnt  out  8  frame counter

## Operation
- h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800). v_cnt counts 0..V_TOTAL-1 (525). v_cnt advances when h_cnt wraps.
- Line order: active at h 0..H_ACTIVE-1, then FP, SYNC, BP. Frame order is the same for v.
- de_int = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
- vsync active for v in [V_ACTIVE+V_FP, +V_SYNC-1], i.e. [490,491]. Vsync edges align with h=0; there is no half-line offset.
- pattern_sel is latched into pat_q only at h=0, v=0. A change mid-frame takes effect from the next frame.
- Patterns (12 bits per channel, full = 12'hFFF):
  - 0: R=G=B=FFF.
  - 1: 8 bars of H_ACTIVE/8 pixels, in order white, yellow, cyan, green, magenta, red, blue, black. The bar index comes from a bar-width sub-counter, not a divider.
  - 2: R=G=B={h_cnt[9:0],2'b00}.
  - 3: white when ((h_cnt+frame_cnt)[4] ^ v_cnt[4]), else black. 16-pixel squares scroll 1 px/frame. The addition is 11 bits, truncated.
- Blanking: vid_d = 0.
- frame_cnt increments when h=0, v=0 is reached (after the first frame). It wraps 255->0.
- enable low: counters are forced to h=0, v=0 and outputs go to the idle state. When enable rises, the first output cycle is h=0, v=0, with frame_start pulsing.

## Timing
- Reset/idle output values: vid_de=0, vid_hsync=~HS_POL, vid_vsync=~VS_POL, vid_d=0, frame_start=0. Reset additionally clears frame_cnt to 0 and pat_q to 0.
- All outputs are registered with a fixed 1-cycle latency from counter state, so de, syncs, data and frame_start are mutually aligned.
- Reset takes priority over enable. Asserting reset mid-frame returns outputs to idle values on the next clock edge.
- Frame period: H_TOTAL*V_TOTAL = 420000 cycles (16.8 ms at 25 MHz).
- pattern_sel latch and frame_cnt update occur on the same edge that loads h=0, v=0.

## Test plan
- Reset: hold reset 5 cycles with enable=1 -> vid_de=0, vid_hsync=1, vid_vsync=1, vid_d=0, frame_cnt=0 throughout.
- Line timing, pattern 0: de high exactly 640 cycles, vid_d=36'hFFFFFFFFF; hsync low 96 cycles starting 16 cycles after de falls; line period 800.
- Frame timing: vsync low exactly 1600 cycles, starting 10 lines after the last de; frame_start period 420000; frame_cnt reaches 255 then wraps to 0 after 256 frames (shortened-parameter build allowed).
- Colour bars (pattern 1): pixel 79 -> FFFFFFFFF; pixel 80 -> FFFFFF000; pixel 240 -> 000FFF000; pixel 639 -> 000000000.
- Pattern switch: pattern_sel 0->2 at line 100 -> remainder of frame stays white; next frame pixel 639 = 9FC on all channels.
- Disruptions: enable dropped mid-line -> outputs idle next cycle; re-enable -> frame_start on first output cycle. Reset mid-frame -> idle next cycle, frame_cnt=0.
